upc_loop_activity_counter: RTL and testbench
============================================

Name: upc_loop_activity_counter

Overview:
Synthesizable activity monitor for one HLS-generated pipelined loop block and its enclosing non-dataflow module. It observes the block's ap_start/ap_ready/ap_done/ap_continue handshake and its pipeline FSM state, stage-block and stage-enable signals. It tracks invocation, iteration, stall and latency statistics as registered counters. It sits beside the monitored block as a passive observer: all ports are inputs except the statistics outputs.

Parameters:
STATE_W, 1, width of the observed FSM state vector (one-hot, pipeline stage0 only).
CNT_W, 32, width of every counter output.

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-low reset.
ap_start  in  1  module start.
ap_ready  in  1  module ready.
ap_done  in  1  module done.
ap_continue  in  1  module continue (tie 1 when unused).
cur_state  in  STATE_W  loop FSM current state.
iter_start_state  in  STATE_W  state in which an iteration starts.
iter_end_state  in  STATE_W  state in which an iteration ends.
quit_state  in  STATE_W  state in which the loop may quit.
iter_start_block  in  1  stall at the iteration-start stage.
iter_end_block  in  1  stall at the iteration-end stage.
quit_block  in  1  stall at the quit stage.
iter_start_enable  in  1  pipeline iter0 enable.
iter_end_enable  in  1  last-iteration-stage enable.
quit_enable  in  1  quit stage enable.
loop_start  in  1  loop ap_start.
loop_ready  in  1  loop ap_ready.
loop_done  in  1  loop internal done.
loop_continue  in  1  loop continue.
quit_at_end  in  1  1 means the quit is qualified at the end stage (use the iter_end signals); 0 means use the quit signals.
finish  in  1  simulation/system finish; freezes statistics.
mod_busy  out  1  module state is not M_IDLE.
loop_busy  out  1  loop state is not L_IDLE.
mod_txn_cnt  out  CNT_W  completed module transactions.
loop_inv_cnt  out  CNT_W  completed loop invocations.
iter_start_cnt  out  CNT_W  iterations started.
iter_end_cnt  out  CNT_W  iterations finished.
stall_cnt  out  CNT_W  cycles the loop was busy but blocked.
last_latency  out  CNT_W  cycles of the most recent completed loop invocation.
frozen  out  1  statistics frozen by finish.

Behaviour:
- Reset (reset=0, asynchronous): all counters 0, last_latency 0, both FSMs idle, frozen 0.
- All outputs are registered. An event on cycle N is visible on the outputs at cycle N+1.
- Events, evaluated combinationally each rising edge:
  - start_ev = (cur_state==iter_start_state) & iter_start_enable & ~iter_start_block.
  - end_ev = (cur_state==iter_end_state) & iter_end_enable & ~iter_end_block.
  - stall_ev = loop_busy & (iter_start_block | iter_end_block | quit_block).
- Module FSM:
  - M_IDLE -> M_BUSY when ap_start=1.
  - In M_BUSY, when ap_done=1: if ap_continue=1, mod_txn_cnt increments and the FSM goes to M_IDLE (or stays M_BUSY if ap_start=1 that same cycle); if ap_continue=0, go to M_DONE.
  - M_DONE -> M_IDLE on ap_continue=1, and mod_txn_cnt increments then.
  - ap_ready is observed only; it does not affect counts.
- Loop FSM (L_IDLE/L_ACTIVE/L_HOLD):
  - L_IDLE -> L_ACTIVE when loop_start=1. The latency accumulator loads 1 on that cycle.
  - While L_ACTIVE, the accumulator increments every cycle.
  - In L_ACTIVE, when loop_done=1:
    - If loop_continue=1: loop_inv_cnt increments and last_latency takes the accumulator value including this cycle. Next state is L_ACTIVE with the accumulator reloaded to 1 if loop_start=1, else L_IDLE.
    - If loop_continue=0: go to L_HOLD; the accumulator keeps counting.
  - L_HOLD -> L_IDLE on loop_continue=1, with the same capture as above.
- iter_start_cnt increments on start_ev; iter_end_cnt increments on end_ev; both are independent of FSM state.
- quit_state/quit_enable are inputs only and do not drive the quit decision; loop completion is taken from loop_done.
- stall_cnt increments on stall_ev.
- Counter overflow: every counter saturates at all-ones and never wraps.
- finish: the first rising edge with finish=1 sets frozen, which is sticky until reset. While frozen, no counter, latency or FSM register updates. Events on the edge that sets frozen are still counted.
- Reset mid-invocation discards the partial latency and returns to idle immediately.

Decomposition:
- Package upc_mon_pkg holds the mod_state_e (M_IDLE, M_BUSY, M_DONE) and loop_state_e (L_IDLE, L_ACTIVE, L_HOLD) enums, and a saturating-increment function.
- One sub-module, sat_counter (CNT_W, inc, freeze, async active-low reset), is instantiated for each counter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with activity on the inputs -> all outputs 0, mod_busy=0, loop_busy=0.
- Single invocation:
  - Stimulus: loop_start pulse at cycle 0; stage enable high with cur_state==iter_start_state==iter_end_state for 4 cycles; no block; loop_done=1 at cycle 5; loop_continue=1.
  - Expected: iter_start_cnt=4, iter_end_cnt=4, loop_inv_cnt=1, last_latency=6.
- Stall: during an invocation assert iter_start_block for 3 cycles -> stall_cnt=3, and start_ev is not counted during those 3 cycles.
- Module done held: ap_start, then ap_done=1 with ap_continue=0 for 2 cycles, then ap_continue=1 -> mod_txn_cnt stays 0 until the continue cycle, then reads 1; mod_busy stays 1 through M_DONE.
- Freeze: finish=1 mid-invocation, then 10 more iterations -> counts equal the values at the finish edge; frozen=1.
- Saturation: with CNT_W=3, 9 loop invocations -> loop_inv_cnt=7.

Source files
------------

// File: rtl/upc_mon_pkg.sv
// Shared state encodings and the saturating-increment helper for the loop
// activity monitor.
package upc_mon_pkg;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_BUSY = 2'd1,
    M_DONE = 2'd2
  } mod_state_e;

  typedef enum logic [1:0] {
    L_IDLE   = 2'd0,
    L_ACTIVE = 2'd1,
    L_HOLD   = 2'd2
  } loop_state_e;

  localparam int unsigned MAX_CNT_W = 64;

  // Callers zero-extend into the wide argument and truncate the result back.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input int unsigned width);
    logic [MAX_CNT_W-1:0] maxVal;
    maxVal = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - width);
    return (value >= maxVal) ? maxVal : value + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones and holds while frozen.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] count_o
);
  import upc_mon_pkg::*;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !freeze_i) begin
      count_d = CNT_W'(sat_inc(MAX_CNT_W'(count_q), CNT_W));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/upc_loop_activity_counter.sv
// Passive observer of an HLS pipelined loop and its enclosing module: counts
// transactions, invocations, iterations and stalls, and records loop latency.
module upc_loop_activity_counter #(
  parameter int unsigned STATE_W = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  input  logic               finish,
  output logic               mod_busy,
  output logic               loop_busy,
  output logic [CNT_W-1:0]   mod_txn_cnt,
  output logic [CNT_W-1:0]   loop_inv_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   last_latency,
  output logic               frozen
);
  import upc_mon_pkg::*;

  mod_state_e       modState_q, modState_d;
  loop_state_e      loopState_q, loopState_d;
  logic [CNT_W-1:0] latAcc_q, latAcc_d;
  logic [CNT_W-1:0] lastLat_q, lastLat_d;
  logic [CNT_W-1:0] latNext;
  logic             frozen_q;
  logic             startEv, endEv, stallEv;
  logic             modTxnInc, loopInvInc;
  logic             unused_inputs;

  // Loop completion comes from loop_done alone; the quit-stage and ready
  // signals are observed but never qualify anything.
  assign unused_inputs = ^{ap_ready, quit_state, quit_enable, quit_at_end, loop_ready};

  assign startEv = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
  assign endEv   = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
  assign stallEv = (loopState_q != L_IDLE) && (iter_start_block || iter_end_block || quit_block);

  always_comb begin
    modState_d = modState_q;
    modTxnInc  = 1'b0;
    case (modState_q)
      M_IDLE: if (ap_start) modState_d = M_BUSY;
      M_BUSY: begin
        if (ap_done) begin
          if (ap_continue) begin
            modTxnInc  = 1'b1;
            modState_d = ap_start ? M_BUSY : M_IDLE;
          end else begin
            modState_d = M_DONE;
          end
        end
      end
      M_DONE: begin
        if (ap_continue) begin
          modTxnInc  = 1'b1;
          modState_d = M_IDLE;
        end
      end
      default: modState_d = M_IDLE;
    endcase
  end

  // The accumulator counts the start cycle as 1, so the captured latency
  // includes both the start and the completing cycle.
  always_comb begin
    latNext     = CNT_W'(sat_inc(MAX_CNT_W'(latAcc_q), CNT_W));
    loopState_d = loopState_q;
    latAcc_d    = latAcc_q;
    lastLat_d   = lastLat_q;
    loopInvInc  = 1'b0;
    case (loopState_q)
      L_IDLE: begin
        if (loop_start) begin
          loopState_d = L_ACTIVE;
          latAcc_d    = CNT_W'(1);
        end
      end
      L_ACTIVE: begin
        latAcc_d = latNext;
        if (loop_done) begin
          if (loop_continue) begin
            loopInvInc = 1'b1;
            lastLat_d  = latNext;
            if (loop_start) begin
              latAcc_d = CNT_W'(1);
            end else begin
              loopState_d = L_IDLE;
            end
          end else begin
            loopState_d = L_HOLD;
          end
        end
      end
      L_HOLD: begin
        latAcc_d = latNext;
        if (loop_continue) begin
          loopInvInc  = 1'b1;
          lastLat_d   = latNext;
          loopState_d = L_IDLE;
        end
      end
      default: loopState_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      modState_q  <= M_IDLE;
      loopState_q <= L_IDLE;
      latAcc_q    <= '0;
      lastLat_q   <= '0;
      frozen_q    <= 1'b0;
    end else if (!frozen_q) begin
      modState_q  <= modState_d;
      loopState_q <= loopState_d;
      latAcc_q    <= latAcc_d;
      lastLat_q   <= lastLat_d;
      frozen_q    <= finish;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) uModTxn (
    .clock(clock), .reset(reset), .inc_i(modTxnInc), .freeze_i(frozen_q), .count_o(mod_txn_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uLoopInv (
    .clock(clock), .reset(reset), .inc_i(loopInvInc), .freeze_i(frozen_q), .count_o(loop_inv_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uIterStart (
    .clock(clock), .reset(reset), .inc_i(startEv), .freeze_i(frozen_q), .count_o(iter_start_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uIterEnd (
    .clock(clock), .reset(reset), .inc_i(endEv), .freeze_i(frozen_q), .count_o(iter_end_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uStall (
    .clock(clock), .reset(reset), .inc_i(stallEv), .freeze_i(frozen_q), .count_o(stall_cnt)
  );

  assign mod_busy     = (modState_q != M_IDLE);
  assign loop_busy    = (loopState_q != L_IDLE);
  assign last_latency = lastLat_q;
  assign frozen       = frozen_q;

endmodule

// File: tb/tb_upc_loop_activity_counter.sv
// Directed bench for upc_loop_activity_counter: a default-width instance plus
// a 3-bit instance sharing the same stimulus to exercise saturation.
module tb_upc_loop_activity_counter;

  logic clock = 1'b0;
  logic reset;
  logic ap_start, ap_ready, ap_done, ap_continue;
  logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end, finish;

  logic        mod_busy, loop_busy, frozen;
  logic [31:0] mod_txn_cnt, loop_inv_cnt, iter_start_cnt, iter_end_cnt, stall_cnt, last_latency;

  logic       satModBusy, satLoopBusy, satFrozen;
  logic [2:0] satModTxn, satLoopInv, satIterStart, satIterEnd, satStall, satLastLat;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  upc_loop_activity_counter #(.STATE_W(1), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
    .mod_busy(mod_busy), .loop_busy(loop_busy),
    .mod_txn_cnt(mod_txn_cnt), .loop_inv_cnt(loop_inv_cnt),
    .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .stall_cnt(stall_cnt), .last_latency(last_latency), .frozen(frozen)
  );

  upc_loop_activity_counter #(.STATE_W(1), .CNT_W(3)) dutSat (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
    .mod_busy(satModBusy), .loop_busy(satLoopBusy),
    .mod_txn_cnt(satModTxn), .loop_inv_cnt(satLoopInv),
    .iter_start_cnt(satIterStart), .iter_end_cnt(satIterEnd),
    .stall_cnt(satStall), .last_latency(satLastLat), .frozen(satFrozen)
  );

  task automatic idleInputs();
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
    cur_state = 1'b0; iter_start_state = 1'b1; iter_end_state = 1'b1; quit_state = 1'b1;
    iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
    iter_start_enable = 1'b0; iter_end_enable = 1'b0; quit_enable = 1'b0;
    loop_start = 1'b0; loop_ready = 1'b0; loop_done = 1'b0; loop_continue = 1'b1;
    quit_at_end = 1'b0; finish = 1'b0;
  endtask

  // Holds the current inputs across n rising edges; outputs are then sampled 1 time unit later.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    idleInputs();
    reset = 1'b0;
    // Activity while reset is held must not register.
    loop_start = 1'b1; ap_start = 1'b1; cur_state = 1'b1;
    iter_start_enable = 1'b1; iter_end_enable = 1'b1; loop_done = 1'b1; ap_done = 1'b1;
    applyStimulus(3);
    checkOutput("reset_mod_busy", 32'(mod_busy), 32'd0);
    checkOutput("reset_loop_busy", 32'(loop_busy), 32'd0);
    checkOutput("reset_mod_txn", mod_txn_cnt, 32'd0);
    checkOutput("reset_loop_inv", loop_inv_cnt, 32'd0);
    checkOutput("reset_iter_start", iter_start_cnt, 32'd0);
    checkOutput("reset_iter_end", iter_end_cnt, 32'd0);
    checkOutput("reset_stall", stall_cnt, 32'd0);
    checkOutput("reset_latency", last_latency, 32'd0);
    checkOutput("reset_frozen", 32'(frozen), 32'd0);
    idleInputs();
    reset = 1'b1;
    applyStimulus(1);

    $display("[TB] single invocation");
    loop_start = 1'b1;
    applyStimulus(1);
    checkOutput("inv1_busy_after_start", 32'(loop_busy), 32'd1);
    loop_start = 1'b0;
    cur_state = 1'b1; iter_start_enable = 1'b1; iter_end_enable = 1'b1;
    applyStimulus(2);
    checkOutput("inv1_iter_start_mid", iter_start_cnt, 32'd2);
    applyStimulus(2);
    checkOutput("inv1_iter_start", iter_start_cnt, 32'd4);
    checkOutput("inv1_iter_end", iter_end_cnt, 32'd4);
    checkOutput("inv1_latency_before_done", last_latency, 32'd0);
    cur_state = 1'b0; iter_start_enable = 1'b0; iter_end_enable = 1'b0;
    loop_done = 1'b1;
    applyStimulus(1);
    loop_done = 1'b0;
    checkOutput("inv1_loop_inv", loop_inv_cnt, 32'd1);
    checkOutput("inv1_latency", last_latency, 32'd6);
    checkOutput("inv1_busy_after_done", 32'(loop_busy), 32'd0);

    $display("[TB] stall");
    iter_start_block = 1'b1;
    applyStimulus(1);
    checkOutput("stall_while_idle", stall_cnt, 32'd0);
    iter_start_block = 1'b0;
    loop_start = 1'b1;
    applyStimulus(1);
    loop_start = 1'b0;
    cur_state = 1'b1; iter_start_enable = 1'b1; iter_start_block = 1'b1;
    applyStimulus(3);
    checkOutput("stall_count", stall_cnt, 32'd3);
    checkOutput("stall_no_start", iter_start_cnt, 32'd4);
    iter_start_block = 1'b0;
    applyStimulus(1);
    checkOutput("stall_start_resumes", iter_start_cnt, 32'd5);
    checkOutput("stall_count_held", stall_cnt, 32'd3);
    cur_state = 1'b0; iter_start_enable = 1'b0;
    applyStimulus(1);
    loop_done = 1'b1;
    applyStimulus(1);
    loop_done = 1'b0;
    checkOutput("stall_loop_inv", loop_inv_cnt, 32'd2);
    checkOutput("stall_latency", last_latency, 32'd7);

    $display("[TB] loop hold");
    loop_start = 1'b1;
    applyStimulus(1);
    loop_start = 1'b0;
    applyStimulus(1);
    loop_done = 1'b1; loop_continue = 1'b0;
    applyStimulus(1);
    checkOutput("hold_busy", 32'(loop_busy), 32'd1);
    loop_done = 1'b0;
    applyStimulus(1);
    checkOutput("hold_loop_inv_waiting", loop_inv_cnt, 32'd2);
    loop_continue = 1'b1;
    applyStimulus(1);
    checkOutput("hold_loop_inv", loop_inv_cnt, 32'd3);
    checkOutput("hold_latency", last_latency, 32'd5);
    checkOutput("hold_busy_released", 32'(loop_busy), 32'd0);

    $display("[TB] back-to-back invocations");
    loop_start = 1'b1;
    applyStimulus(1);
    loop_done = 1'b1;
    applyStimulus(1);
    checkOutput("b2b_loop_inv_first", loop_inv_cnt, 32'd4);
    checkOutput("b2b_latency_first", last_latency, 32'd2);
    checkOutput("b2b_busy", 32'(loop_busy), 32'd1);
    loop_done = 1'b0; loop_start = 1'b0;
    applyStimulus(1);
    loop_done = 1'b1;
    applyStimulus(1);
    loop_done = 1'b0;
    checkOutput("b2b_loop_inv_second", loop_inv_cnt, 32'd5);
    checkOutput("b2b_latency_second", last_latency, 32'd3);

    $display("[TB] module handshake");
    ap_start = 1'b1;
    applyStimulus(1);
    checkOutput("mod_busy_after_start", 32'(mod_busy), 32'd1);
    ap_start = 1'b0; ap_ready = 1'b1;
    applyStimulus(1);
    ap_ready = 1'b0;
    ap_done = 1'b1; ap_continue = 1'b0;
    applyStimulus(2);
    checkOutput("mod_txn_held", mod_txn_cnt, 32'd0);
    checkOutput("mod_busy_in_done", 32'(mod_busy), 32'd1);
    ap_continue = 1'b1;
    applyStimulus(1);
    ap_done = 1'b0;
    checkOutput("mod_txn_continue", mod_txn_cnt, 32'd1);
    checkOutput("mod_busy_released", 32'(mod_busy), 32'd0);
    ap_start = 1'b1;
    applyStimulus(1);
    ap_done = 1'b1;
    applyStimulus(1);
    checkOutput("mod_txn_restart", mod_txn_cnt, 32'd2);
    checkOutput("mod_busy_restart", 32'(mod_busy), 32'd1);
    ap_start = 1'b0;
    applyStimulus(1);
    ap_done = 1'b0;
    checkOutput("mod_txn_final", mod_txn_cnt, 32'd3);
    checkOutput("mod_idle_final", 32'(mod_busy), 32'd0);

    $display("[TB] freeze");
    checkOutput("frozen_before", 32'(frozen), 32'd0);
    loop_start = 1'b1;
    applyStimulus(1);
    loop_start = 1'b0;
    cur_state = 1'b1; iter_start_enable = 1'b1; iter_end_enable = 1'b1;
    applyStimulus(1);
    finish = 1'b1;
    applyStimulus(1);
    finish = 1'b0;
    checkOutput("freeze_set", 32'(frozen), 32'd1);
    checkOutput("freeze_iter_start_at_edge", iter_start_cnt, 32'd7);
    checkOutput("freeze_iter_end_at_edge", iter_end_cnt, 32'd6);
    applyStimulus(10);
    iter_start_block = 1'b1;
    applyStimulus(2);
    iter_start_block = 1'b0;
    loop_done = 1'b1;
    applyStimulus(1);
    loop_done = 1'b0;
    ap_start = 1'b1;
    applyStimulus(1);
    ap_start = 1'b0;
    cur_state = 1'b0; iter_start_enable = 1'b0; iter_end_enable = 1'b0;
    checkOutput("freeze_iter_start", iter_start_cnt, 32'd7);
    checkOutput("freeze_iter_end", iter_end_cnt, 32'd6);
    checkOutput("freeze_stall", stall_cnt, 32'd3);
    checkOutput("freeze_loop_inv", loop_inv_cnt, 32'd5);
    checkOutput("freeze_latency", last_latency, 32'd3);
    checkOutput("freeze_loop_busy", 32'(loop_busy), 32'd1);
    checkOutput("freeze_mod_busy", 32'(mod_busy), 32'd0);
    checkOutput("freeze_mod_txn", mod_txn_cnt, 32'd3);
    checkOutput("freeze_sticky", 32'(frozen), 32'd1);

    $display("[TB] saturation");
    idleInputs();
    reset = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
    checkOutput("sat_frozen_cleared", 32'(frozen), 32'd0);
    checkOutput("sat_loop_inv_cleared", 32'(satLoopInv), 32'd0);
    for (int i = 0; i < 9; i++) begin
      loop_start = 1'b1; cur_state = 1'b1; iter_start_enable = 1'b1;
      applyStimulus(1);
      loop_start = 1'b0; loop_done = 1'b1;
      applyStimulus(1);
      loop_done = 1'b0;
    end
    cur_state = 1'b0; iter_start_enable = 1'b0;
    checkOutput("sat_loop_inv_small", 32'(satLoopInv), 32'd7);
    checkOutput("sat_loop_inv_wide", loop_inv_cnt, 32'd9);
    checkOutput("sat_iter_start_small", 32'(satIterStart), 32'd7);
    checkOutput("sat_iter_start_wide", iter_start_cnt, 32'd18);
    checkOutput("sat_latency_small", 32'(satLastLat), 32'd2);

    $display("[TB] reset mid-invocation");
    loop_start = 1'b1;
    applyStimulus(1);
    loop_start = 1'b0;
    applyStimulus(2);
    checkOutput("midreset_busy_before", 32'(loop_busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy_async", 32'(loop_busy), 32'd0);
    checkOutput("midreset_loop_inv", loop_inv_cnt, 32'd0);
    checkOutput("midreset_latency", last_latency, 32'd0);
    applyStimulus(1);
    reset = 1'b1;
    loop_done = 1'b1;
    applyStimulus(1);
    loop_done = 1'b0;
    checkOutput("midreset_done_ignored", loop_inv_cnt, 32'd0);
    checkOutput("midreset_latency_after", last_latency, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
